logic_op_scheduler: RTL and testbench

- Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between NREQ requesters, e.g. pipeline ALU lane, branch-condition unit and CSR set/clear path.
- Round-robin arbitration, valid/ready handshake on every request port and on the single result port.
- Operands and result are registered.
- Sits between the issue logic and the writeback mux in the RISC core.

---
 rtl/logic_sched_pkg.sv | 17 +
 rtl/logic_unit.sv | 24 ++
 rtl/logic_op_scheduler.sv | 99 +++++++++
 tb/tb_logic_op_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_sched_pkg.sv
// Shared encodings for the logic-op scheduler: operation codes and FSM states.
package logic_sched_pkg;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_NOR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit: AND / OR / XOR / NOR over WIDTH bits.
module logic_unit
   import logic_sched_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_e              op,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NOR:  y = ~(a | b);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logic_op_scheduler.sv
// Round-robin scheduler sharing one logic unit between NREQ requesters, with
// registered operands and a held, valid/ready result port.
module logic_op_scheduler
   import logic_sched_pkg::*;
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 32,
   localparam int unsigned IDW  = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [2*NREQ-1:0]     req_op,
   input  logic [WIDTH*NREQ-1:0] req_a,
   input  logic [WIDTH*NREQ-1:0] req_b,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [WIDTH-1:0]      res_data,
   output logic [IDW-1:0]        res_id
);

   state_e           state;
   logic [IDW-1:0]   rr_ptr;
   op_e              op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IDW-1:0]   id_q;
   logic [WIDTH-1:0] unit_y;
   logic             grant_found;
   logic [IDW-1:0]   grant;

   // First valid requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      grant_found = 1'b0;
      grant       = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         int unsigned idx;
         idx = (32'(rr_ptr) + k) % NREQ;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant       = IDW'(idx);
         end
      end
   end

   assign req_ready = (!rst && state == ST_IDLE && grant_found) ?
                      (NREQ'(1) << grant) : '0;

   logic_unit #(
      .WIDTH (WIDTH)
   ) u_logic_unit (
      .a  (a_q),
      .b  (b_q),
      .op (op_q),
      .y  (unit_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         op_q      <= OP_AND;
         a_q       <= '0;
         b_q       <= '0;
         id_q      <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_found) begin
                  op_q  <= op_e'(req_op[2*grant +: 2]);
                  a_q   <= req_a[WIDTH*grant +: WIDTH];
                  b_q   <= req_b[WIDTH*grant +: WIDTH];
                  id_q  <= grant;
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               res_data  <= unit_y;
               res_id    <= id_q;
               res_valid <= 1'b1;
               state     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  rr_ptr    <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Directed scoreboard bench for logic_op_scheduler (NREQ=4, WIDTH=32).
module tb_logic_op_scheduler;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [7:0]   req_op;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic         res_valid;
   logic         res_ready;
   logic [31:0]  res_data;
   logic [1:0]   res_id;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_acc = -1;
   logic [33:0] sb_q[$];

   logic_op_scheduler #(
      .NREQ  (4),
      .WIDTH (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      req_op[2*i +: 2] = op;
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   // Scoreboard: pop and compare on every result handshake.
   always @(negedge clk) begin
      #2;
      if (!rst && res_valid === 1'b1 && res_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected", 32'(res_id), 32'hFFFF_FFFF);
         end else begin
            logic [33:0] e;
            e = sb_q.pop_front();
            chk("sb_id", 32'(res_id), 32'(e[33:32]));
            chk("sb_data", res_data, e[31:0]);
         end
      end
   end

   // One full transaction starting and ending on a negedge in IDLE.
   task automatic txn(input logic [3:0] mask, input int g, input int hold, input bit chk_gap);
      logic [31:0] exp_d;
      exp_d = model(req_op[2*g +: 2], req_a[32*g +: 32], req_b[32*g +: 32]);
      req_valid = mask;
      #1;
      chk("grant", 32'(req_ready), 32'(4'b0001 << g));
      if (chk_gap) chk("accept_gap", 32'(cyc - last_acc), 32'd3);
      last_acc = cyc;
      sb_q.push_back({2'(g), exp_d});
      @(negedge clk);
      res_ready = (hold == 0);
      chk("exec_valid", 32'(res_valid), 32'd0);
      chk("exec_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      #1;
      chk("latency_valid", 32'(res_valid), 32'd1);
      chk("hold_data", res_data, exp_d);
      chk("hold_id", 32'(res_id), 32'(g));
      for (int i = 1; i < hold; i++) begin
         req_valid = 4'b1111 ^ 4'(i);
         @(negedge clk);
         #1;
         chk("bp_valid", 32'(res_valid), 32'd1);
         chk("bp_data", res_data, exp_d);
         chk("bp_ready", 32'(req_ready), 32'd0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      chk("done_valid", 32'(res_valid), 32'd0);
      req_valid = 4'b0000;
   endtask

   // Start an operation and reset it during EXEC or HOLD.
   task automatic abort(input logic [3:0] mask, input int g, input bit at_hold);
      res_ready = 1'b0;
      req_valid = mask;
      #1;
      chk("abort_grant", 32'(req_ready), 32'(4'b0001 << g));
      @(negedge clk);
      req_valid = 4'b0000;
      if (at_hold) begin
         @(negedge clk);
         chk("abort_hold_valid", 32'(res_valid), 32'd1);
      end
      rst = 1'b1;
      req_valid = 4'b1111;
      @(negedge clk);
      #1;
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_data", res_data, 32'd0);
      chk("rst_id", 32'(res_id), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      req_valid = 4'b0000;
      res_ready = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 4'b1111;
      res_ready = 1'b1;
      req_op = '0;
      req_a = '0;
      req_b = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_valid", 32'(res_valid), 32'd0);
      chk("reset_data", res_data, 32'd0);
      chk("reset_id", 32'(res_id), 32'd0);
      chk("reset_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      req_valid = 4'b0000;
      @(negedge clk);

      // Single OR from requester 0.
      set_req(0, 2'b01, 32'hF0F0_0000, 32'h0000_0F0F);
      txn(4'b0001, 0, 0, 1'b0);
      chk("or_model", model(2'b01, 32'hF0F0_0000, 32'h0000_0F0F), 32'hF0F0_0F0F);

      // Round robin from a fresh pointer.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      set_req(0, 2'b00, 32'h1234_5678, 32'h0F0F_0F0F);
      set_req(1, 2'b01, 32'hA5A5_0000, 32'h0000_5A5A);
      set_req(2, 2'b10, 32'hDEAD_BEEF, 32'hFFFF_0000);
      set_req(3, 2'b11, 32'h0000_00FF, 32'hFF00_0000);
      txn(4'b1111, 0, 0, 1'b0);
      txn(4'b1111, 1, 0, 1'b1);
      txn(4'b1111, 2, 0, 1'b1);
      txn(4'b1111, 3, 0, 1'b1);
      txn(4'b1111, 0, 0, 1'b1);

      // Backpressure on an XOR for 5 cycles.
      set_req(2, 2'b10, 32'hFFFF_FFFF, 32'h1234_5678);
      txn(4'b0100, 2, 5, 1'b0);
      chk("xor_model", model(2'b10, 32'hFFFF_FFFF, 32'h1234_5678), 32'hEDCB_A987);

      // NOR of zeros, then pointer wrap 3 -> 0 with AND boundary value.
      set_req(3, 2'b11, 32'h0, 32'h0);
      txn(4'b1000, 3, 0, 1'b0);
      set_req(0, 2'b00, 32'h8000_0001, 32'hFFFF_FFFF);
      txn(4'b1001, 0, 0, 1'b0);

      // Reset during EXEC, then requester 2 alone.
      abort(4'b0010, 1, 1'b0);
      sb_q.delete();
      txn(4'b0100, 2, 0, 1'b0);

      // Reset during HOLD; pointer must restart at 0.
      abort(4'b1000, 3, 1'b1);
      sb_q.delete();
      txn(4'b1111, 0, 0, 1'b0);

      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
